// File: rtl/ds_temp_ctrl.sv
// DS18B20 measurement sequencer: runs reset/SKIP ROM/CONVERT T, waits for the
// conversion, then reads scratchpad bytes 0 and 1 through the byte layer.
module ds_temp_ctrl #(
  parameter int unsigned CONV_WAIT = 37_500_000,
  parameter int unsigned CNT_W     = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        rst_en,
  output logic        wr_en,
  output logic [7:0]  wdata,
  output logic        rd_en,
  input  logic [7:0]  rdata,
  input  logic        rdata_vld,
  input  logic        rdy,
  output logic [15:0] temp_raw,
  output logic        temp_sign,
  output logic [10:0] temp_abs,
  output logic        temp_vld,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST1, S_SKIP1, S_CONV, S_WAIT, S_RST2,
    S_SKIP2, S_RDCMD, S_RDL, S_RDH, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_WAIT - 1);

  state_t           state_q, state_d;
  logic             issued_q, issued_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lsb_q, lsb_d;
  logic             rst_en_q, rst_en_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic [15:0]      temp_raw_q, temp_raw_d;
  logic             temp_sign_q, temp_sign_d;
  logic [10:0]      temp_abs_q, temp_abs_d;
  logic             temp_vld_q, temp_vld_d;
  logic             req_busy;
  logic             cmd_done;
  logic [15:0]      raw_new;

  // Byte-layer handshake: a request is a one-cycle pulse issued only when rdy=1
  // and no request is in flight; a command completes once rdy is back at 1 with
  // every request low (reads complete on rdata_vld instead). The request for the
  // next state is decided in the completing cycle so it can appear on entry.
  assign req_busy = rst_en_q | wr_en_q | rd_en_q;
  assign cmd_done = issued_q & rdy & ~req_busy;
  assign raw_new  = {rdata, lsb_q};

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    cnt_d       = cnt_q;
    lsb_d       = lsb_q;
    rst_en_d    = 1'b0;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    wdata_d     = wdata_q;
    temp_raw_d  = temp_raw_q;
    temp_sign_d = temp_sign_q;
    temp_abs_d  = temp_abs_q;
    temp_vld_d  = 1'b0;

    case (state_q)
      S_IDLE:  if (start) state_d = S_RST1;
      S_RST1:  if (cmd_done) state_d = S_SKIP1;
      S_SKIP1: if (cmd_done) state_d = S_CONV;
      S_CONV:  if (cmd_done) state_d = S_WAIT;
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_RST2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RST2:  if (cmd_done) state_d = S_SKIP2;
      S_SKIP2: if (cmd_done) state_d = S_RDCMD;
      S_RDCMD: if (cmd_done) state_d = S_RDL;
      S_RDL: begin
        if (issued_q && rdata_vld) begin
          lsb_d   = rdata;
          state_d = S_RDH;
        end
      end
      S_RDH: begin
        if (issued_q && rdata_vld) begin
          temp_raw_d  = raw_new;
          temp_sign_d = raw_new[15];
          temp_abs_d  = raw_new[15] ? 11'(~raw_new[10:0] + 11'd1) : raw_new[10:0];
          temp_vld_d  = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) issued_d = 1'b0;

    if (!issued_d && rdy && !req_busy) begin
      case (state_d)
        S_RST1, S_RST2: begin
          rst_en_d = 1'b1;
          issued_d = 1'b1;
        end
        S_SKIP1, S_SKIP2: begin
          wr_en_d  = 1'b1;
          wdata_d  = 8'hCC;
          issued_d = 1'b1;
        end
        S_CONV: begin
          wr_en_d  = 1'b1;
          wdata_d  = 8'h44;
          issued_d = 1'b1;
        end
        S_RDCMD: begin
          wr_en_d  = 1'b1;
          wdata_d  = 8'hBE;
          issued_d = 1'b1;
        end
        S_RDL, S_RDH: begin
          rd_en_d  = 1'b1;
          issued_d = 1'b1;
        end
        default: ;
      endcase
    end

    // busy drops in the result cycle so it falls together with temp_vld
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      issued_q    <= 1'b0;
      cnt_q       <= '0;
      lsb_q       <= 8'h00;
      rst_en_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wdata_q     <= 8'h00;
      busy_q      <= 1'b0;
      temp_raw_q  <= 16'h0000;
      temp_sign_q <= 1'b0;
      temp_abs_q  <= 11'd0;
      temp_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      cnt_q       <= cnt_d;
      lsb_q       <= lsb_d;
      rst_en_q    <= rst_en_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      temp_raw_q  <= temp_raw_d;
      temp_sign_q <= temp_sign_d;
      temp_abs_q  <= temp_abs_d;
      temp_vld_q  <= temp_vld_d;
    end
  end

  assign busy      = busy_q;
  assign rst_en    = rst_en_q;
  assign wr_en     = wr_en_q;
  assign wdata     = wdata_q;
  assign rd_en     = rd_en_q;
  assign temp_raw  = temp_raw_q;
  assign temp_sign = temp_sign_q;
  assign temp_abs  = temp_abs_q;
  assign temp_vld  = temp_vld_q;
  assign dbg_state = state_q;

endmodule
